// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } conv_state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam int         BCD_NIBBLE_W  = 4;

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Request/result handshake bundle for bcd_to_binary_seq.
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin_out;
    logic                  digit_err;

    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, bin_out, digit_err
    );

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, bin_out, digit_err
    );
endinterface

// File: rtl/bcd_mul10_add.sv
// One Horner step: sum = acc*10 + digit, truncated to BIN_W bits.
module bcd_mul10_add
    import bcd_pkg::*;
#(
    parameter int BIN_W = 10
) (
    input  logic [BIN_W-1:0]        acc,
    input  logic [BCD_NIBBLE_W-1:0] digit,
    output logic [BIN_W-1:0]        sum
);
    // x10 as x8 + x2 keeps this to shifts and adders
    logic [BIN_W-1:0] acc_x8;
    logic [BIN_W-1:0] acc_x2;

    assign acc_x8 = acc << 3;
    assign acc_x2 = acc << 1;
    assign sum    = acc_x8 + acc_x2 + BIN_W'(digit);
endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic               clk,
    input  logic               reset,
    bcd_to_binary_seq_if.slave bus
);
    localparam int CNT_W = $clog2(DIGITS) + 1;
    localparam int SR_W  = BCD_NIBBLE_W * DIGITS;

    conv_state_t       state_q, state_d;
    logic [BIN_W-1:0]  acc_q, acc_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic              derr_q, derr_d;

    logic [BCD_NIBBLE_W-1:0] digit;
    logic [BIN_W-1:0]        mac;

    assign digit = sr_q[SR_W-1 -: BCD_NIBBLE_W];

    bcd_mul10_add #(.BIN_W(BIN_W)) u_mac (
        .acc   (acc_q),
        .digit (digit),
        .sum   (mac)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        bin_d   = bin_q;
        derr_d  = derr_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sr_d    = bus.bcd_in;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(DIGITS - 1);
                    err_d   = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d = mac;
                err_d = err_q | (digit > BCD_DIGIT_MAX);
                sr_d  = sr_q << BCD_NIBBLE_W;
                if (cnt_q == '0) begin
                    // latch the result so bin_out holds it after returning to IDLE
                    bin_d   = mac;
                    derr_d  = err_d;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            bin_q   <= '0;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            bin_q   <= bin_d;
            derr_q  <= derr_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.bin_out   = bin_q;
    assign bus.digit_err = derr_q;
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed scoreboard bench for bcd_to_binary_seq (DIGITS=3, BIN_W=10).
module tb_bcd_to_binary_seq;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bcd_to_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus();

    bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request; returns at the negedge after the accepting edge.
    task automatic send(input logic [11:0] bcd, input bit push,
                        input logic [BIN_W-1:0] eb, input logic ee);
        exp_t e;
        @(negedge clk);
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.bcd_in   = bcd;
        if (push) begin
            e.bin = eb;
            e.err = ee;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.bcd_in   = '0;
    endtask

    // Wait for the result, optionally hold it off and poke in_valid, then consume it.
    task automatic collect(input string tag, input int hold, input bit poke);
        int   lat = 0;
        exp_t e;
        while (!bus.out_valid && lat < 20) begin
            if (lat == 0) check({tag, "_in_ready_conv"}, 32'(bus.in_ready), 32'd0);
            if (poke && lat == 1) begin
                bus.in_valid = 1'b1;
                bus.bcd_in   = 12'h777;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(DIGITS));
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_bin"}, 32'(bus.bin_out), 32'(e.bin));
            check({tag, "_hold_err"}, 32'(bus.digit_err), 32'(e.err));
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            bus.in_valid = poke && (i == 1);
            bus.bcd_in   = 12'h777;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check({tag, "_bin"}, 32'(bus.bin_out), 32'(e.bin));
        check({tag, "_err"}, 32'(bus.digit_err), 32'(e.err));
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.bcd_in    = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_bin_out", 32'(bus.bin_out), 32'd0);
        check("rst_digit_err", 32'(bus.digit_err), 32'd0);

        send(12'h123, 1'b1, 10'd123, 1'b0); collect("c123", 0, 1'b0);
        send(12'h999, 1'b1, 10'h3E7, 1'b0); collect("c999", 0, 1'b0);
        send(12'h000, 1'b1, 10'd0,   1'b0); collect("c000", 0, 1'b0);
        send(12'h009, 1'b1, 10'd9,   1'b0); collect("c009", 0, 1'b0);
        send(12'h1A5, 1'b1, 10'd205, 1'b1); collect("c1A5", 0, 1'b0);
        send(12'h042, 1'b1, 10'd42,  1'b0); collect("c042", 0, 1'b0);

        // backpressure with stray requests during CONV and DONE
        bus.out_ready = 1'b0;
        send(12'h058, 1'b1, 10'd58, 1'b0);
        collect("bp058", 5, 1'b1);
        repeat (DIGITS + 2) @(negedge clk);
        check("bp_no_stray_valid", 32'(bus.out_valid), 32'd0);
        check("bp_bin_kept", 32'(bus.bin_out), 32'd58);

        // asynchronous reset in the middle of a conversion
        send(12'h456, 1'b0, '0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_bin_out", 32'(bus.bin_out), 32'd0);
        check("arst_digit_err", 32'(bus.digit_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send(12'h321, 1'b1, 10'd321, 1'b0); collect("c321", 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
